// File: rtl/frame_builder_if.sv
// Byte-wide valid/ready transmit stream between the frame builder and the UART TX path.
interface frame_builder_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_builder.sv
// Serialises a latched 64-bit payload into a 13-byte command frame
// (HEADER, LENGTH, CMD, D0..D7, CHK, TAIL), one byte per valid/ready transfer.
module frame_builder #(
  parameter logic [7:0] HEADER     = 8'h52,
  parameter logic [7:0] LENGTH     = 8'h0E,
  parameter logic [7:0] CMD        = 8'h01,
  parameter logic [7:0] TAIL       = 8'h9A,
  parameter logic [7:0] CHK_TARGET = 8'h01,
  localparam int unsigned PAYLOAD_W = 64,
  localparam int unsigned BYTE_W    = 8,
  localparam int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 En,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] payload,
  frame_builder_if.master      tx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, HDR, LEN, CMDB, DATA, CHK, TAILB, FIN} state_t;

  state_t               state;
  logic [PAYLOAD_W-1:0] pl_q;
  logic [BYTE_W-1:0]    sum_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BYTE_W-1:0]    data_q;
  logic                 valid_q;

  logic                 xfer_c;
  logic [2:0]           nxt_idx_c;
  logic [BYTE_W-1:0]    nxt_data_c;
  logic [BYTE_W-1:0]    d0_c;
  logic [BYTE_W-1:0]    chk_c;

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

  // Next data byte is selected from the latched payload, MSB byte first.
  assign xfer_c     = valid_q && tx.tx_ready;
  assign nxt_idx_c  = 3'd6 - cnt_q[2:0];
  assign nxt_data_c = pl_q[{nxt_idx_c, 3'b000} +: BYTE_W];
  assign d0_c       = pl_q[PAYLOAD_W-1 -: BYTE_W];
  // sum_q holds HEADER..D7 once D7 is on the bus, so CHK closes the frame to CHK_TARGET.
  assign chk_c      = CHK_TARGET - TAIL - sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pl_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!En) begin
      state   <= IDLE;
      pl_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pl_q    <= payload;
            sum_q   <= HEADER;
            data_q  <= HEADER;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            cnt_q   <= '0;
            state   <= HDR;
          end
        end
        HDR: begin
          if (xfer_c) begin
            data_q <= LENGTH;
            sum_q  <= sum_q + LENGTH;
            state  <= LEN;
          end
        end
        LEN: begin
          if (xfer_c) begin
            data_q <= CMD;
            sum_q  <= sum_q + CMD;
            state  <= CMDB;
          end
        end
        CMDB: begin
          if (xfer_c) begin
            data_q <= d0_c;
            sum_q  <= sum_q + d0_c;
            cnt_q  <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (xfer_c) begin
            if (cnt_q == CNT_W'(7)) begin
              data_q <= chk_c;
              sum_q  <= sum_q + chk_c;
              state  <= CHK;
            end else begin
              data_q <= nxt_data_c;
              sum_q  <= sum_q + nxt_data_c;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        CHK: begin
          if (xfer_c) begin
            data_q <= TAIL;
            sum_q  <= sum_q + TAIL;
            state  <= TAILB;
          end
        end
        TAILB: begin
          if (xfer_c) begin
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Bench for frame_builder: frame-level byte-queue model checked every cycle plus literal frame checks.
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [63:0] payload = '0;
  logic        busy;
  logic        done;

  frame_builder_if tx_if ();
  assign tx_if.tx_ready = tx_ready;

  frame_builder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .En      (en),
    .start   (start),
    .payload (payload),
    .tx      (tx_if),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  localparam logic [103:0] FRAME1 = 104'h520E010102030405060708E29A;
  localparam logic [63:0]  P1     = 64'h0102030405060708;

  int n_cmp = 0;
  int n_fail = 0;
  int cd = 0;
  int done_cnt = 0;
  int valid_cycles = 0;
  bit mon_en = 1'b0;
  bit idle;
  logic [103:0] fr;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame from first principles: fixed fields, payload MSB-first, CHK closing the byte sum to 01.
  function automatic logic [103:0] build_frame(input logic [63:0] p);
    logic [7:0] b[13];
    logic [7:0] s;
    logic [103:0] r;
    b[0] = 8'h52; b[1] = 8'h0E; b[2] = 8'h01; b[12] = 8'h9A;
    for (int i = 0; i < 8; i++) b[3+i] = p[63-8*i -: 8];
    s = 8'h00;
    for (int i = 0; i < 13; i++) if (i != 11) s = s + b[i];
    b[11] = 8'h01 - s;
    r = '0;
    for (int i = 0; i < 13; i++) r = {r[95:0], b[i]};
    return r;
  endfunction

  function automatic logic [103:0] cap_pack();
    logic [103:0] r;
    r = '0;
    for (int i = 0; i < 13 && i < cap_q.size(); i++) r = {r[95:0], cap_q[i]};
    return r;
  endfunction

  function automatic logic [7:0] cap_sum();
    logic [7:0] s;
    s = 8'h00;
    foreach (cap_q[i]) s = s + cap_q[i];
    return s;
  endfunction

  // Per-cycle compare against the byte-queue model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        exp_q.delete();
        cd = 0;
      end
      idle = (exp_q.size() == 0) && (cd == 0);
      check("tx_valid", tx_if.tx_valid, exp_q.size() > 0);
      check("busy", busy, exp_q.size() > 0);
      check("done", done, cd == 1);
      if (exp_q.size() > 0) check("tx_data", tx_if.tx_data, exp_q[0]);
      if (tx_if.tx_valid) valid_cycles++;
      if (done) done_cnt++;
      if (cd > 0) cd--;
      if (rst_n) begin
        if (!en) begin
          exp_q.delete();
          cd = 0;
        end else begin
          if (tx_if.tx_valid && tx_ready) cap_q.push_back(tx_if.tx_data);
          if (exp_q.size() > 0 && tx_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) cd = 1;
          end else if (idle && start) begin
            fr = build_frame(payload);
            for (int i = 0; i < 13; i++) exp_q.push_back(fr[103-8*i -: 8]);
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] p);
    @(posedge clk); #1;
    payload = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    check("frame_timeout", done_cnt > d0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [63:0] p);
    int d0;
    cap_q.delete();
    valid_cycles = 0;
    d0 = done_cnt;
    send(p);
    wait_frame(d0);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_if.tx_valid, 1'b0);
    check("rst_tx_data", tx_if.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    en = 1'b1;
    tx_ready = 1'b1;
    mon_en = 1'b1;

    fr = build_frame(P1);
    check("model_frame1", fr, FRAME1);
    fr = build_frame(64'h0);
    check("model_chk_zero", fr[15:8], 8'h06);
    fr = build_frame(64'hFFFF_FFFF_FFFF_FFFF);
    check("model_chk_ones", fr[15:8], 8'h0E);

    // Streaming frame with ready held high
    run_frame(P1);
    check("case1_len", cap_q.size(), 13);
    check("case1_bytes", cap_pack(), FRAME1);
    check("case1_valid_cycles", valid_cycles, 13);

    // Checksum corner payloads
    run_frame(64'h0);
    check("zero_len", cap_q.size(), 13);
    check("zero_chk", cap_q[11], 8'h06);
    check("zero_sum", cap_sum(), 8'h01);
    run_frame(64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_len", cap_q.size(), 13);
    check("ones_chk", cap_q[11], 8'h0E);
    check("ones_sum", cap_sum(), 8'h01);

    // Random backpressure
    cap_q.delete();
    tx_ready = 1'b0;
    d0 = done_cnt;
    send(P1);
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
    check("bp_timeout", done_cnt > d0, 1'b1);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_bytes", cap_pack(), FRAME1);
    check("bp_len", cap_q.size(), 13);

    // Start mid-frame with a new payload is ignored
    cap_q.delete();
    d0 = done_cnt;
    send(P1);
    repeat (4) @(posedge clk);
    #1;
    payload = 64'hDEAD_BEEF_CAFE_F00D;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame(d0);
    check("restart_bytes", cap_pack(), FRAME1);
    check("restart_done", done_cnt - d0, 1);

    // Enable drop after the fifth transfer aborts the frame
    cap_q.delete();
    d0 = done_cnt;
    send(P1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_sent", cap_q.size(), 5);
    en = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", tx_if.tx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    run_frame(P1);
    check("after_abort_bytes", cap_pack(), FRAME1);

    // Async reset mid-DATA
    send(P1);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", tx_if.tx_valid, 1'b0);
    check("arst_data", tx_if.tx_data, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", tx_if.tx_valid, 1'b0);
    run_frame(P1);
    check("post_rst_bytes", cap_pack(), FRAME1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
